// File: rtl/ui_event_scheduler.sv
// ui_event_scheduler: merges one-cycle button pulses and handshaked network
// commands into one ordered event stream held in a first-word-fall-through
// queue, and tracks the incoming-call ringing state.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   enter/up/down/left/right        one-cycle debounced button pulses
//   inc_valid, inc_command[2:0]     network command in; inc_ready is combinational
//   ev_valid, ev_code[3:0]          queue head out; ev_ready from consumer
//   ringing                         incoming call pending
//   dropped                         registered one-cycle pulse per cycle a button was lost
//
// Optional feature macro: UI_EVQ_RING_TIMEOUT_EN (missed-call timeout after
// RING_CYCLES cycles of ringing). When undefined, no timer is built.
module ui_event_scheduler #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [26:0] RING_CYCLES = 27'd100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       inc_valid,
  input  logic [2:0] inc_command,
  output logic       inc_ready,
  output logic       ev_valid,
  output logic [3:0] ev_code,
  input  logic       ev_ready,
  output logic       ringing,
  output logic       dropped
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [2:0] CMD_RING   = 3'd1;
  localparam logic [2:0] CMD_CANCEL = 3'd2;
  localparam logic [3:0] EV_MISSED  = 4'h6;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RINGING = 1'b1
  } ring_state_e;

  // Queue storage and pointers
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  ring_state_e   state_q, state_d;
  logic          dropped_q, dropped_d;
  logic          miss_pend;

  logic [4:0]    btn_vec;
  logic          any_btn;
  logic          multi_btn;
  logic [3:0]    btn_code;
  logic          full;
  logic          inc_acc;
  logic          push;
  logic          push_btn;
  logic          push_miss;
  logic [3:0]    push_code;
  logic          pop;
  logic          answer;
  logic          cancel;
  logic          ring_acc;

  // Button decode: enter > up > down > left > right
  assign btn_vec   = {enter, up, down, left, right};
  assign any_btn   = |btn_vec;
  // More than one bit set: clearing the lowest set bit leaves something
  assign multi_btn = |(btn_vec & (btn_vec - 5'd1));

  always_comb begin
    btn_code = 4'h0;
    if (enter)      btn_code = 4'h1;
    else if (up)    btn_code = 4'h2;
    else if (down)  btn_code = 4'h3;
    else if (left)  btn_code = 4'h4;
    else if (right) btn_code = 4'h5;
  end

  // Full is judged on the registered count only; a same-cycle pop does not
  // free a slot for a push.
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign inc_ready = !reset && !full && !any_btn && !miss_pend;
  assign inc_acc   = inc_valid && inc_ready;
  assign ring_acc  = inc_acc && (inc_command == CMD_RING);
  assign cancel    = inc_acc && (inc_command == CMD_CANCEL);

  // Single write slot: pending missed call > button > network command
  always_comb begin
    push      = 1'b0;
    push_btn  = 1'b0;
    push_miss = 1'b0;
    push_code = 4'h0;
    if (!full) begin
      if (miss_pend) begin
        push      = 1'b1;
        push_miss = 1'b1;
        push_code = EV_MISSED;
      end else if (any_btn) begin
        push      = 1'b1;
        push_btn  = 1'b1;
        push_code = btn_code;
      end else if (inc_acc && (inc_command != 3'd0)) begin
        push      = 1'b1;
        push_code = {1'b1, inc_command};
      end
    end
  end

  assign answer    = push_btn && enter;
  // Losing buttons, or a winner that could not be written, count as a drop
  assign dropped_d = any_btn && (multi_btn || full || miss_pend);

  assign ev_valid = (count_q != '0);
  assign pop      = ev_valid && ev_ready;
  assign ev_code  = ev_valid ? mem_q[rd_ptr_q] : 4'h0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_code;
  end

`ifdef UI_EVQ_RING_TIMEOUT_EN
  logic [26:0] timer_q, timer_d;
  logic        miss_q, miss_d;
  logic        miss_set;

  assign miss_pend = miss_q;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    miss_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ring_acc) begin
          state_d = ST_RINGING;
          timer_d = RING_CYCLES - 27'd1;
        end
      end
      ST_RINGING: begin
        // Answer/cancel take precedence over an expiry in the same cycle
        if (ring_acc) begin
          timer_d = RING_CYCLES - 27'd1;
        end else if (answer || cancel) begin
          state_d = ST_IDLE;
        end else if (timer_q == 27'd0) begin
          state_d  = ST_IDLE;
          miss_set = 1'b1;
        end else begin
          timer_d = timer_q - 27'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    miss_d = miss_q;
    if (push_miss) miss_d = 1'b0;
    if (miss_set)  miss_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= 27'd0;
      miss_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      miss_q  <= miss_d;
    end
  end
`else
  assign miss_pend = 1'b0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (ring_acc) state_d = ST_RINGING;
      ST_RINGING: if (!ring_acc && (answer || cancel)) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= ST_IDLE;
      dropped_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      dropped_q <= dropped_d;
    end
  end

  assign ringing = (state_q == ST_RINGING);
  assign dropped = dropped_q;

endmodule

// File: tb/tb_ui_event_scheduler.sv
module tb_ui_event_scheduler;

  localparam int DEPTH = 4;
  localparam int RC    = 8;

  logic       clk;
  logic       reset;
  logic       enter, up, down, left, right;
  logic       inc_valid;
  logic [2:0] inc_command;
  logic       inc_ready;
  logic       ev_valid;
  logic [3:0] ev_code;
  logic       ev_ready;
  logic       ringing;
  logic       dropped;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: event list, call status, pending missed call, last drop
  logic [3:0] m_q[$];
  bit         m_ring = 0;
  int         m_tmr  = 0;
  bit         m_miss = 0;
  bit         m_drop = 0;

  ui_event_scheduler #(.FIFO_DEPTH(DEPTH), .RING_CYCLES(27'(RC))) dut (
    .clk(clk), .reset(reset),
    .enter(enter), .up(up), .down(down), .left(left), .right(right),
    .inc_valid(inc_valid), .inc_command(inc_command), .inc_ready(inc_ready),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_ready(ev_ready),
    .ringing(ringing), .dropped(dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int n_buttons();
    return int'(enter) + int'(up) + int'(down) + int'(left) + int'(right);
  endfunction

  function automatic bit model_inc_ready();
    return !reset && (m_q.size() < DEPTH) && (n_buttons() == 0) && !m_miss;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    int         nb;
    logic [3:0] bc;
    logic [3:0] code;
    bit         full, acc, do_push, do_pop, answered, new_drop;
    if (reset) begin
      m_q.delete();
      m_ring = 0; m_tmr = 0; m_miss = 0; m_drop = 0;
      return;
    end
    nb = n_buttons();
    bc = enter ? 4'h1 : up ? 4'h2 : down ? 4'h3 : left ? 4'h4 : right ? 4'h5 : 4'h0;
    full     = (m_q.size() >= DEPTH);
    acc      = inc_valid && !full && (nb == 0) && !m_miss;
    new_drop = (nb > 0) && ((nb > 1) || full || m_miss);
    do_pop   = (m_q.size() > 0) && ev_ready;
    do_push  = 0; answered = 0; code = 4'h0;
    if (!full) begin
      if (m_miss) begin
        do_push = 1; code = 4'h6; m_miss = 0;
      end else if (nb > 0) begin
        do_push = 1; code = bc; answered = (bc == 4'h1);
      end else if (acc && inc_command != 3'd0) begin
        do_push = 1; code = {1'b1, inc_command};
      end
    end
    if (do_pop)  void'(m_q.pop_front());
    if (do_push) m_q.push_back(code);
    if (acc && inc_command == 3'd1) begin
      m_ring = 1; m_tmr = RC - 1;
    end else if (m_ring) begin
      if (answered || (acc && inc_command == 3'd2)) m_ring = 0;
`ifdef UI_EVQ_RING_TIMEOUT_EN
      else if (m_tmr == 0) begin m_ring = 0; m_miss = 1; end
      else m_tmr = m_tmr - 1;
`endif
    end
    m_drop = new_drop;
  endtask

  // One clock: model follows the DUT edge, return at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; inc_valid = 1; inc_command = 3'd3;
    tick(); tick();
    #1;
    n_cmp++; if (inc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_inc_ready got %b want 0", inc_ready); end
    n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ev_valid got %b want 0", ev_valid); end
    n_cmp++; if (ev_code !== 4'h0) begin n_fail++; $display("FAIL reset_ev_code got %h want 0", ev_code); end
    n_cmp++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL reset_ringing got %b want 0", ringing); end
    n_cmp++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL reset_dropped got %b want 0", dropped); end
    inc_valid = 0; reset = 0;
    tick();
  endtask

  task automatic test_single_up();
    for (int i = 0; i < 8; i++) tick();
    up = 1;
    tick();
    up = 0; #1;
    n_cmp++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL up_valid got %b want 1", ev_valid); end
    n_cmp++; if (ev_code !== 4'h2) begin n_fail++; $display("FAIL up_code got %h want 2", ev_code); end
    ev_ready = 1;
    tick(); #1;
    n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL up_popped got %b want 0", ev_valid); end
    ev_ready = 0;
  endtask

  task automatic test_collision();
    enter = 1; left = 1;
    tick();
    enter = 0; left = 0; #1;
    n_cmp++; if (ev_code !== 4'h1) begin n_fail++; $display("FAIL coll_code got %h want 1", ev_code); end
    n_cmp++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL coll_dropped got %b want 1", dropped); end
    ev_ready = 1;
    tick(); #1;
    n_cmp++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL coll_drop_pulse got %b want 0", dropped); end
    n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL coll_single got %b want 0", ev_valid); end
    ev_ready = 0;
  endtask

  task automatic test_full_stall();
    logic [3:0] exp [4];
    exp[0] = 4'h5; exp[1] = 4'h5; exp[2] = 4'h5; exp[3] = 4'hD;
    for (int i = 0; i < 5; i++) begin
      right = 1;
      tick();
    end
    right = 0; #1;
    n_cmp++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL full_dropped got %b want 1", dropped); end
    inc_valid = 1; inc_command = 3'd5; #1;
    n_cmp++; if (inc_ready !== 1'b0) begin n_fail++; $display("FAIL full_stall0 got %b want 0", inc_ready); end
    tick(); #1;
    n_cmp++; if (inc_ready !== 1'b0) begin n_fail++; $display("FAIL full_stall1 got %b want 0", inc_ready); end
    ev_ready = 1; #1;
    n_cmp++; if (inc_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_cycle got %b want 0", inc_ready); end
    tick();
    ev_ready = 0; #1;
    n_cmp++; if (inc_ready !== 1'b1) begin n_fail++; $display("FAIL full_after_pop got %b want 1", inc_ready); end
    tick();
    inc_valid = 0; ev_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (ev_valid !== 1'b1 || ev_code !== exp[i]) begin n_fail++; $display("FAIL full_drain%0d got %b/%h want 1/%h", i, ev_valid, ev_code, exp[i]); end
      tick();
    end
    #1;
    n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty got %b want 0", ev_valid); end
    ev_ready = 0;
  endtask

  task automatic test_ring_answer();
    inc_valid = 1; inc_command = 3'd1; #1;
    n_cmp++; if (inc_ready !== 1'b1) begin n_fail++; $display("FAIL ring_ready got %b want 1", inc_ready); end
    tick();
    inc_valid = 0; #1;
    n_cmp++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL ring_rise got %b want 1", ringing); end
    enter = 1;
    tick();
    enter = 0; #1;
    n_cmp++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL ring_answer got %b want 0", ringing); end
    ev_ready = 1;
    n_cmp++; if (ev_code !== 4'h9) begin n_fail++; $display("FAIL ring_ev0 got %h want 9", ev_code); end
    tick(); #1;
    n_cmp++; if (ev_code !== 4'h1) begin n_fail++; $display("FAIL ring_ev1 got %h want 1", ev_code); end
    tick(); #1;
    n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL ring_empty got %b want 0", ev_valid); end
    ev_ready = 0;
  endtask

  task automatic test_timeout();
    ev_ready = 1;
    inc_valid = 1; inc_command = 3'd1;
    tick();
    inc_valid = 0;
`ifdef UI_EVQ_RING_TIMEOUT_EN
    for (int i = 1; i <= RC; i++) begin
      #1;
      n_cmp++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL tmo_ring%0d got %b want 1", i, ringing); end
      tick();
    end
    #1;
    n_cmp++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL tmo_fall got %b want 0", ringing); end
    tick(); #1;
    n_cmp++; if (ev_valid !== 1'b1 || ev_code !== 4'h6) begin n_fail++; $display("FAIL tmo_missed got %b/%h want 1/6", ev_valid, ev_code); end
    tick();
`else
    for (int i = 0; i < 20; i++) begin
      #1;
      n_cmp++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL persist%0d got %b want 1", i, ringing); end
      tick();
    end
    inc_valid = 1; inc_command = 3'd2;
    tick();
    inc_valid = 0; #1;
    n_cmp++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL cancel got %b want 0", ringing); end
    tick();
`endif
    tick();
    ev_ready = 0;
  endtask

  task automatic test_reset_mid();
    ev_ready = 0;
    inc_valid = 1; inc_command = 3'd1;
    tick();
    inc_valid = 0; up = 1;
    tick();
    up = 0; left = 1;
    tick();
    left = 0; reset = 1;
    tick();
    reset = 0; #1;
    n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", ev_valid); end
    n_cmp++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL rstmid_ringing got %b want 0", ringing); end
    down = 1;
    tick();
    down = 0; ev_ready = 1; #1;
    n_cmp++; if (ev_code !== 4'h3) begin n_fail++; $display("FAIL rstmid_code got %h want 3", ev_code); end
    tick(); #1;
    n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_only got %b want 0", ev_valid); end
    ev_ready = 0;
  endtask

  task automatic test_random();
    logic [4:0] b;
    logic       e_valid;
    logic [3:0] e_code;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      b = ($urandom_range(0, 9) < 2) ? 5'($urandom_range(1, 31)) : 5'd0;
      {enter, up, down, left, right} = b;
      inc_valid   = 1'($urandom_range(0, 1));
      inc_command = 3'($urandom_range(0, 7));
      ev_ready    = ($urandom_range(0, 2) == 0);
      #1;
      e_valid = (m_q.size() != 0);
      e_code  = e_valid ? m_q[0] : 4'h0;
      n_cmp++; if (ev_valid !== e_valid || ev_code !== e_code) begin n_fail++; $display("FAIL rnd_head c%0d got %b/%h want %b/%h", c, ev_valid, ev_code, e_valid, e_code); end
      n_cmp++; if (ringing !== m_ring) begin n_fail++; $display("FAIL rnd_ringing c%0d got %b want %b", c, ringing, m_ring); end
      n_cmp++; if (dropped !== m_drop) begin n_fail++; $display("FAIL rnd_dropped c%0d got %b want %b", c, dropped, m_drop); end
      n_cmp++; if (inc_ready !== model_inc_ready()) begin n_fail++; $display("FAIL rnd_inc_ready c%0d got %b want %b", c, inc_ready, model_inc_ready()); end
      tick();
    end
    reset = 0;
    {enter, up, down, left, right} = 5'd0;
    inc_valid = 0; ev_ready = 0;
  endtask

  initial begin
    reset = 1; enter = 0; up = 0; down = 0; left = 0; right = 0;
    inc_valid = 0; inc_command = 3'd0; ev_ready = 0;
    @(negedge clk);
    test_reset();
    test_single_up();
    test_collision();
    test_full_stall();
    test_ring_answer();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
